// File: rtl/shared_divider.sv
// Two-client restoring divider: round-robin grant, one quotient bit per clock,
// results and owner held until the next operation replaces them.
module shared_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             req_a,
    input  logic [WIDTH-1:0] dividend_a,
    input  logic [WIDTH-1:0] divisor_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] dividend_b,
    input  logic [WIDTH-1:0] divisor_b,
    output logic             select,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] dividerres,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, CALC} state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             sel_q, sel_d;
    logic             last_b_q, last_b_d;
    logic             dz_q, dz_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] res_rem_q, res_rem_d;

    logic             grant, grant_b, fits;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff, rem_next, quo_next;

    always_comb begin
        grant_b  = req_b & (~req_a | ~last_b_q);
        grant    = en & (req_a | req_b);
        trial    = {rem_q, dvd_q[WIDTH-1]};
        fits     = (trial >= {1'b0, dvs_q});
        // Only used when fits: the true difference is below the divisor, so mod-2^WIDTH is exact.
        diff     = trial[WIDTH-1:0] - dvs_q;
        rem_next = fits ? diff : trial[WIDTH-1:0];
        quo_next = {dvd_q[WIDTH-2:0], fits};
    end

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        ready_d   = 1'b0;
        sel_d     = sel_q;
        last_b_d  = last_b_q;
        dz_d      = dz_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        res_rem_d = res_rem_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    sel_d    = grant_b;
                    last_b_d = grant_b;
                    dvd_d    = grant_b ? dividend_b : dividend_a;
                    dvs_d    = grant_b ? divisor_b : divisor_a;
                    rem_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = CALC;
                end
            end
            CALC: begin
                rem_d = rem_next;
                dvd_d = quo_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    quo_d     = quo_next;
                    res_rem_d = rem_next;
                    dz_d      = (dvs_q == '0);
                    busy_d    = 1'b0;
                    ready_d   = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            sel_q     <= 1'b0;
            last_b_q  <= 1'b1;
            dz_q      <= 1'b0;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            res_rem_q <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            sel_q     <= sel_d;
            last_b_q  <= last_b_d;
            dz_q      <= dz_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            res_rem_q <= res_rem_d;
        end
    end

    assign select     = sel_q;
    assign busy       = busy_q;
    assign ready      = ready_q;
    assign dividerres = quo_q;
    assign remainder  = res_rem_q;
    assign div_zero   = dz_q;

endmodule

// File: tb/tb_shared_divider.sv
// Directed bench for shared_divider (WIDTH=16): hand-computed quotients,
// arbitration order, latency, reset abort and back-to-back operation.
module tb_shared_divider;

    logic        clk = 1'b0;
    logic        rst, en, req_a, req_b;
    logic [15:0] dividend_a, divisor_a, dividend_b, divisor_b;
    logic        select, busy, ready, div_zero;
    logic [15:0] dividerres, remainder;

    int n_cmp = 0;
    int n_err = 0;

    shared_divider #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_a(req_a), .dividend_a(dividend_a), .divisor_a(divisor_a),
        .req_b(req_b), .dividend_b(dividend_b), .divisor_b(divisor_b),
        .select(select), .busy(busy), .ready(ready),
        .dividerres(dividerres), .remainder(remainder), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge, with the request for the next grant edge already set up.
    task automatic finish_op(input string tag, input bit exp_sel, input logic [15:0] eq,
                             input logic [15:0] er, input bit edz, input bit raise_b);
        int edges = 0;
        int nbusy = 0;
        bit got = 0;
        bit ovl = 0;
        while (!got && edges < 40) begin
            @(negedge clk);
            edges++;
            if (busy) nbusy++;
            if (busy && ready) ovl = 1;
            if (edges == 1) begin
                check({tag, " busy@grant"}, busy, 1);
                check({tag, " select"}, select, exp_sel);
                if (exp_sel) req_b = 1'b0; else req_a = 1'b0;
                if (raise_b) req_b = 1'b1;
            end
            if (ready) got = 1;
        end
        check({tag, " ready seen"}, got, 1);
        check({tag, " latency"}, edges, 17);
        check({tag, " busy cycles"}, nbusy, 16);
        check({tag, " ready&busy"}, ovl, 0);
        check({tag, " quotient"}, dividerres, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " div_zero"}, div_zero, edz);
    endtask

    task automatic set_a(input logic [15:0] dd, input logic [15:0] ds);
        dividend_a = dd; divisor_a = ds; req_a = 1'b1;
    endtask

    task automatic set_b(input logic [15:0] dd, input logic [15:0] ds);
        dividend_b = dd; divisor_b = ds; req_b = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        int nb;
        rst = 1'b1; en = 1'b1; req_a = 1'b0; req_b = 1'b0;
        dividend_a = '0; divisor_a = '0; dividend_b = '0; divisor_b = '0;
        repeat (2) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset ready", ready, 0);
        check("reset select", select, 0);
        check("reset quotient", dividerres, 0);
        check("reset remainder", remainder, 0);
        check("reset div_zero", div_zero, 0);
        rst = 1'b0;
        @(negedge clk);

        set_a(16'd36000, 16'd600);
        finish_op("A 36000/600", 0, 16'd60, 16'd0, 0, 0);
        dividend_a = 16'd1; divisor_a = 16'd1;
        @(negedge clk);
        check("hold ready low", ready, 0);
        check("hold quotient", dividerres, 16'd60);

        set_b(16'd1000, 16'd7);
        finish_op("B 1000/7", 1, 16'd142, 16'd6, 0, 0);
        @(negedge clk);

        set_a(16'd100, 16'd10);
        set_b(16'd81, 16'd9);
        finish_op("pair1 A", 0, 16'd10, 16'd0, 0, 0);
        finish_op("pair1 B", 1, 16'd9, 16'd0, 0, 0);
        @(negedge clk);

        set_a(16'd1234, 16'd0);
        finish_op("A 1234/0", 0, 16'hFFFF, 16'd1234, 1, 0);
        @(negedge clk);

        set_a(16'd200, 16'd20);
        set_b(16'd5, 16'd9);
        finish_op("pair2 B", 1, 16'd0, 16'd5, 0, 0);
        finish_op("pair2 A", 0, 16'd10, 16'd0, 0, 0);
        @(negedge clk);

        // Abort a B operation after five division steps.
        set_b(16'd36000, 16'd600);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) req_b = 1'b0;
            if (ready) seen = 1;
        end
        check("abort no ready", seen, 0);
        check("abort select before rst", select, 1);
        rst = 1'b1;
        #1;
        check("rst busy", busy, 0);
        check("rst ready", ready, 0);
        check("rst select", select, 0);
        check("rst quotient", dividerres, 0);
        check("rst remainder", remainder, 0);
        check("rst div_zero", div_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post-rst idle", busy, 0);
        set_a(16'd50, 16'd7);
        finish_op("A 50/7", 0, 16'd7, 16'd1, 0, 0);
        @(negedge clk);

        // req_b raised once A is running and held through A's ready cycle.
        set_a(16'd36000, 16'd600);
        dividend_b = 16'd1000; divisor_b = 16'd7;
        finish_op("b2b A", 0, 16'd60, 16'd0, 0, 1);
        finish_op("b2b B", 1, 16'd142, 16'd6, 0, 0);
        @(negedge clk);

        en = 1'b0;
        set_a(16'd9, 16'd3);
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) nb++;
        end
        check("en=0 busy cycles", nb, 0);
        req_a = 1'b0;
        en = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
